uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmitter feeding the serial input of the UART receive path.
//  - Accepts one byte over a valid/ready handshake.
//  - Serialises it as: start bit (0), DATA_BITS data bits LSB first, optional even-parity bit, STOP_BITS stop bits (1).
//  - Bit timing comes from an internal divider on i_clk.
// PARAMETERS
//  CLKS_PER_BIT  8  i_clk cycles per serial bit (>=2); 8 matches the receiver's F/8 baud clock
//  DATA_BITS     8  data bits per frame (5..8)
//  STOP_BITS     1  stop bits per frame (1 or 2)
// PORTS
//  i_clk    in   1          system clock, all logic on posedge
//  i_reset  in   1          asynchronous, active-low reset
//  i_data   in   DATA_BITS  byte to send; sampled only on an accepting edge
//  i_valid  in   1          i_data is valid
//  o_ready  out  1          block can accept a byte this cycle
//  o_txd    out  1          serial line, idles high
//  o_busy   out  1          frame in progress
//  o_done   out  1          1-cycle pulse in the last cycle of the final stop bit
// BEHAVIOUR
//  Reset (async, i_reset=0):
//   - state=IDLE, o_txd=1, o_ready=1, o_busy=0, o_done=0.
//   - bit counter and divider cleared.
//   - Applies immediately, including mid-frame; the partial frame is abandoned.
//  Handshake:
//   - Accept on a posedge with i_valid&&o_ready; i_data is latched into the shift register.
//   - o_ready=0 and o_busy=1 from the next cycle.
//   - i_valid while o_ready=0 is ignored; i_data changes mid-frame have no effect.
//  FSM states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
//   - IDLE:   o_txd=1; exits on accept.
//   - START:  o_txd=0 for CLKS_PER_BIT cycles, beginning the cycle after accept (latency 1).
//   - DATA:   DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles; 3-bit index counts 0..DATA_BITS-1.
//   - PARITY: present only with UART_TX_PARITY_EN.
//   - STOP:   o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Divider:
//   - Counts 0..CLKS_PER_BIT-1, $clog2(CLKS_PER_BIT) bits wide.
//   - Wraps to 0 on each bit boundary; the state/bit index advances on the wrap.
//   - Cleared in IDLE.
//  Output timing:
//   - o_txd is registered (glitch-free).
//   - Each bit is exactly CLKS_PER_BIT cycles.
//  End of frame / back-to-back:
//   - In the last cycle of STOP: o_done=1 and o_ready=1.
//   - An accept on that edge goes straight to START with no idle bit between frames.
//   - Otherwise the FSM returns to IDLE.
//  Frame length: (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles; P=1 with parity, else 0.
// CONFIGURATION
//  UART_TX_PARITY_EN
//   - Defined: a PARITY state follows DATA and sends even parity = ^data_latched
//     (total count of 1s over data+parity is even), matching the receiver's parity checker.
//   - Undefined: DATA goes directly to STOP; no parity logic is synthesised.
// TESTING  (CLKS_PER_BIT=8, DATA_BITS=8, STOP_BITS=1, UART_TX_PARITY_EN defined unless noted)
//  1. Hold i_reset=0 -> o_txd=1, o_ready=1, o_busy=0. Release reset, keep i_valid=0 for 100 clocks
//     -> o_txd stays 1.
//  2. Send 0xA5 -> o_txd bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each 8 clocks.
//     o_done pulses 88 clocks after accept.
//  3. Send 0x01 -> parity bit=1. Loopback into the receive path gives o_dataout=0x01 with no parity error.
//  4. Assert i_valid with 0x55 and hold it, with 0xAA presented at the o_done cycle
//     -> the 0xAA start bit immediately follows the 0x55 stop bit; 176 clocks total, no gap.
//  5. Pulse i_valid with 0x3C while o_busy=1 -> ignored. The frame in flight completes unchanged.
//  6. Assert i_reset=0 during DATA bit 3 -> o_txd=1 asynchronously, o_ready=1.
//     Next accept of 0x0F sends a full, correct frame.
//  7. Parity macro undefined: send 0xA5 -> 10-bit frame, stop bit directly after bit 7, 80 clocks.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmitter.
//   Takes one word over a valid/ready handshake and sends it as a serial frame:
//   start bit (0), DATA_BITS data bits LSB first, an optional even-parity bit,
//   and STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT i_clk cycles.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY bit (even parity over the data)
//                      follows the last data bit. When undefined, the frame
//                      goes straight from DATA to STOP.
//
// Ports:
//   i_clk    in   1          system clock, posedge
//   i_reset  in   1          asynchronous active-low reset
//   i_data   in   DATA_BITS  word to send, latched on the accepting edge
//   i_valid  in   1          i_data valid
//   o_ready  out  1          a word can be accepted this cycle
//   o_txd    out  1          serial line (registered), idles high
//   o_busy   out  1          frame in progress
//   o_done   out  1          pulse in the last cycle of the final stop bit
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int              DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DIV_W-1:0]       r_div;
  logic [2:0]             r_bit;      // data index in DATA, stop-bit index in STOP
  logic [2:0]             w_bit_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_txd;
  logic                   w_txd_nxt;
  logic                   w_tick;     // last cycle of the current bit
  logic                   w_last;     // last cycle of the frame
  logic                   w_accept;

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  assign w_parity = ^r_data;
`endif

  assign w_tick   = (r_state != S_IDLE) && (r_div == DIV_LAST);
  assign w_last   = (r_state == S_STOP) && w_tick && (r_bit == STOP_LAST);
  assign w_accept = i_valid && o_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: if (w_tick)   w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick && (r_bit == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        // An accept in the final stop cycle chains the next frame with no idle gap.
        if (w_last) w_state_nxt = w_accept ? S_START : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy  = (r_state != S_IDLE);
    o_ready = (r_state == S_IDLE) || w_last;
    o_done  = w_last;
  end

  assign o_txd = r_txd;

  // Bit index and the next line level both follow the next state, so the line
  // register already holds the right level in the first cycle of each bit.
  always_comb begin
    w_bit_nxt = r_bit;
    if (w_state_nxt != r_state) w_bit_nxt = 3'd0;
    else if (w_tick)            w_bit_nxt = r_bit + 3'd1;
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = r_data[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_parity;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div  <= '0;
      r_bit  <= 3'd0;
      r_data <= '0;
      r_txd  <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) || w_tick) r_div <= '0;
      else                               r_div <= r_div + 1'b1;
      r_bit <= w_bit_nxt;
      if (w_accept) r_data <= i_data;
      r_txd <= w_txd_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame -- directed bench for uart_tx_frame (8 clocks/bit, 8 data
// bits, 1 stop bit). Expected frames are pushed to a scoreboard when a word is
// offered and popped when the serial frame is checked cycle by cycle. Parity
// expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;

  localparam int CPB = 8;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NB  = 1 + DB + PB + SB;
  localparam int FL  = NB * CPB;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_data  = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_txd, o_busy, o_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_txd(o_txd), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Frame model: bit 0 = start, then data LSB first, optional even parity, stop bits.
  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DB; i++) b[1+i] = d[i];
    if (PB == 1) b[1+DB] = ^d;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [7:0] d);
    chk({tag, "_ready"}, 16'(o_ready), 16'd1);
    i_data  = d;
    i_valid = 1'b1;
    sb_q.push_back(frame_bits(d));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_txd_%0d", tag, k),   16'(o_txd),   16'd1);
      chk($sformatf("%s_busy_%0d", tag, k),  16'(o_busy),  16'd0);
      chk($sformatf("%s_ready_%0d", tag, k), 16'(o_ready), 16'd1);
      chk($sformatf("%s_done_%0d", tag, k),  16'(o_done),  16'd0);
      tick();
    end
  endtask

  // Called in frame cycle 1 (the cycle after the accept edge). Checks every
  // cycle of the frame; o_done and o_ready must be high only in cycle FL.
  // chain: offer nb in the last cycle so the next frame follows with no gap.
  // pulse_at: cycle in which a one-cycle i_valid with 0x3C is offered (-1: none).
  task automatic check_frame(input string tag, input bit chain, input logic [7:0] nb,
                             input int pulse_at);
    logic [15:0] exp;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_scoreboard: observed empty expected a frame", tag);
      return;
    end
    exp = sb_q.pop_front();
    for (int c = 1; c <= FL; c++) begin
      chk($sformatf("%s_txd_c%0d", tag, c),   16'(o_txd),   16'(exp[(c-1)/CPB]));
      chk($sformatf("%s_done_c%0d", tag, c),  16'(o_done),  16'(c == FL));
      chk($sformatf("%s_ready_c%0d", tag, c), 16'(o_ready), 16'(c == FL));
      chk($sformatf("%s_busy_c%0d", tag, c),  16'(o_busy),  16'd1);
      if (c == pulse_at) begin
        i_data  = 8'h3C;
        i_valid = 1'b1;
      end else if (c == pulse_at + 1) begin
        i_valid = 1'b0;
      end
      if (c == FL && chain) begin
        i_data  = nb;
        i_valid = 1'b1;
        sb_q.push_back(frame_bits(nb));
      end
      tick();
      if (c == FL && chain) i_valid = 1'b0;
    end
  endtask

  initial begin
    // 1. reset state, then a long idle stretch
    #1 i_reset = 1'b0;
    #2;
    chk("rst_txd",   16'(o_txd),   16'd1);
    chk("rst_ready", 16'(o_ready), 16'd1);
    chk("rst_busy",  16'(o_busy),  16'd0);
    chk("rst_done",  16'(o_done),  16'd0);
    tick();
    tick();
    chk("rst_hold_txd", 16'(o_txd), 16'd1);
    @(negedge i_clk) i_reset = 1'b1;
    tick();
    check_idle("t1_idle", 100);

    // 2. 0xA5
    send("t2", 8'hA5);
    check_frame("t2", 1'b0, 8'h00, -1);
    check_idle("t2_idle", 3);

    // 3. 0x01 (parity bit 1 when enabled)
    send("t3", 8'h01);
    check_frame("t3", 1'b0, 8'h00, -1);
    check_idle("t3_idle", 2);

    // 4. back-to-back: i_valid held through the 0x55 frame, 0xAA at the done cycle
    send("t4", 8'h55);
    i_valid = 1'b1;
    check_frame("t4a", 1'b1, 8'hAA, -1);
    check_frame("t4b", 1'b0, 8'h00, -1);
    check_idle("t4_idle", 3);

    // 5. i_valid pulse with 0x3C mid-frame is ignored
    send("t5", 8'h5A);
    check_frame("t5", 1'b0, 8'h00, 20);
    check_idle("t5_idle", 12);

    // 6. async reset during data bit 3 (frame cycles 33..40), then a clean frame
    send("t6", 8'hF0);
    void'(sb_q.pop_front());
    for (int k = 0; k < 35; k++) tick();
    chk("t6_pre_txd",  16'(o_txd),  16'd0);
    chk("t6_pre_busy", 16'(o_busy), 16'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("t6_rst_txd",   16'(o_txd),   16'd1);
    chk("t6_rst_ready", 16'(o_ready), 16'd1);
    chk("t6_rst_busy",  16'(o_busy),  16'd0);
    chk("t6_rst_done",  16'(o_done),  16'd0);
    @(negedge i_clk) i_reset = 1'b1;
    tick();
    check_idle("t6_idle", 2);
    send("t6b", 8'h0F);
    check_frame("t6b", 1'b0, 8'h00, -1);
    check_idle("t6b_idle", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
